des_top_core: RTL and testbench

Single-key DES (FIPS 46-3) encryption/decryption engine with an on-chip key schedule and a fully pipelined 16-round datapath. A 64-bit key is loaded on a one-cycle strobe, expanded into 16 stored 48-bit subkeys in the order for the selected direction, and then 64-bit blocks stream in at one per clock. It sits between a key/control register interface and a block-stream producer/consumer.

---
 rtl/des_top_core.sv | 215 +++++++++++++++++++++
 tb/tb_des_top_core.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/des_top_core.sv
// Single-key DES engine: iterative key schedule into 16 subkey slots, fully pipelined 16-round datapath.
// Stage 0 registers IP(data); stages 1..16 are Feistel rounds; data_64_out registers FP of the swapped result.
module des_top_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        encrypt,
  input  logic [1:64] keys_64_in,
  input  logic        change_keys_en,
  output logic        subkeys_16_valid,
  input  logic        data_input_en,
  input  logic [1:64] data_64_in,
  output logic [1:64] data_64_out,
  output logic        data_output_valid
);

  localparam int unsigned NUM_ROUNDS = 16;
  localparam int unsigned CNT_W      = 5;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Each row is one S-box in row-major order: index = {b1,b6} * 16 + {b2..b5}.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // Permutations: table entries are 1-based DES bit numbers, DES bit 1 is the vector MSB.
  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    x = perm_e(r) ^ k;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      b = x[6'(47 - 6 * j) -: 6];
      s[5'(31 - 4 * j) -: 4] = 4'(SBOX[3'(j)][{b[5], b[0], b[4:1]}]);
    end
    return perm_p(s);
  endfunction

  typedef enum logic {IDLE_VALID, GEN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      key_q;
  logic             enc_q;
  logic [55:0]      cd_q;
  logic [55:0]      cd_src_c;
  logic [55:0]      cd_rot_c;
  logic [3:0]       slot_c;
  logic             gen_we_c;
  logic [47:0]      subkey_q [NUM_ROUNDS];

  logic [63:0]      ip_c;
  logic [31:0]      l_q [NUM_ROUNDS + 1];
  logic [31:0]      r_q [NUM_ROUNDS + 1];
  logic [NUM_ROUNDS:0] vld_q;

  // Key FSM: strobe or reset restarts generation; count 17 marks completion.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q          <= GEN;
      cnt_q            <= CNT_W'(1);
      key_q            <= '0;
      enc_q            <= 1'b1;
      subkeys_16_valid <= 1'b0;
    end else if (change_keys_en) begin
      state_q          <= GEN;
      cnt_q            <= CNT_W'(1);
      key_q            <= keys_64_in;
      enc_q            <= encrypt;
      subkeys_16_valid <= 1'b0;
    end else if (state_q == GEN) begin
      if (cnt_q == CNT_W'(NUM_ROUNDS + 1)) begin
        state_q          <= IDLE_VALID;
        subkeys_16_valid <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next C/D halves: round 1 starts from PC-1 of the stored key.
  always_comb begin
    cd_src_c = (cnt_q == CNT_W'(1)) ? perm_pc1(key_q) : cd_q;
    cd_rot_c = {cd_src_c[53:28], cd_src_c[55:54], cd_src_c[25:0], cd_src_c[27:26]};
    if (cnt_q == CNT_W'(1) || cnt_q == CNT_W'(2) || cnt_q == CNT_W'(9) || cnt_q == CNT_W'(16))
      cd_rot_c = {cd_src_c[54:28], cd_src_c[55], cd_src_c[26:0], cd_src_c[27]};
    slot_c   = enc_q ? 4'(cnt_q - CNT_W'(1)) : 4'(CNT_W'(NUM_ROUNDS) - cnt_q);
    gen_we_c = !rst_n && !change_keys_en && (state_q == GEN) &&
               (cnt_q != CNT_W'(NUM_ROUNDS + 1));
  end

  always_ff @(posedge clk) begin
    if (gen_we_c) begin
      cd_q             <= cd_rot_c;
      subkey_q[slot_c] <= perm_pc2(cd_rot_c);
    end
  end

  assign ip_c = perm_ip(data_64_in);

  // Round datapath; qualification is carried entirely by vld_q.
  always_ff @(posedge clk) begin
    l_q[0] <= ip_c[63:32];
    r_q[0] <= ip_c[31:0];
    for (int s = 1; s <= NUM_ROUNDS; s++) begin
      l_q[5'(s)] <= r_q[5'(s - 1)];
      r_q[5'(s)] <= l_q[5'(s - 1)] ^ feistel(r_q[5'(s - 1)], subkey_q[4'(s - 1)]);
    end
  end

  // A key strobe discards every block in flight, including the one about to be emitted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_q             <= '0;
      data_output_valid <= 1'b0;
      data_64_out       <= '0;
    end else begin
      vld_q             <= change_keys_en ? '0 :
                           {vld_q[NUM_ROUNDS-1:0], data_input_en & subkeys_16_valid};
      data_output_valid <= vld_q[NUM_ROUNDS] & ~change_keys_en;
      if (vld_q[NUM_ROUNDS] && !change_keys_en)
        data_64_out <= perm_fp({r_q[NUM_ROUNDS], l_q[NUM_ROUNDS]});
    end
  end

endmodule

// File: tb/tb_des_top_core.sv
// Directed bench for des_top_core using known DES vectors and latency/flush checks.
module tb_des_top_core;

  logic        clk;
  logic        rst_n;
  logic        encrypt;
  logic [1:64] keys_64_in;
  logic        change_keys_en;
  logic        subkeys_16_valid;
  logic        data_input_en;
  logic [1:64] data_64_in;
  logic [1:64] data_64_out;
  logic        data_output_valid;

  int n_cmp = 0;
  int n_bad = 0;

  des_top_core dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .encrypt           (encrypt),
    .keys_64_in        (keys_64_in),
    .change_keys_en    (change_keys_en),
    .subkeys_16_valid  (subkeys_16_valid),
    .data_input_en     (data_input_en),
    .data_64_in        (data_64_in),
    .data_64_out       (data_64_out),
    .data_output_valid (data_output_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_keys(input string tag);
    int lat;
    lat = 0;
    while (subkeys_16_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_key_lat"}, 64'(lat), 64'd17);
  endtask

  task automatic wait_out(input string tag, input int exp_lat, input logic [63:0] exp);
    int lat;
    lat = 0;
    while (data_output_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, data_64_out, exp);
  endtask

  task automatic load_key(input logic [63:0] k, input logic enc);
    keys_64_in     = k;
    encrypt        = enc;
    change_keys_en = 1'b1;
    tick();
    change_keys_en = 1'b0;
  endtask

  task automatic send_one(input string tag, input logic [63:0] d, input logic [63:0] exp);
    data_64_in    = d;
    data_input_en = 1'b1;
    tick();
    data_input_en = 1'b0;
    wait_out(tag, 17, exp);
    tick();
    chk({tag, "_one_cycle"}, 64'(data_output_valid), 64'd0);
  endtask

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_A = 64'h85E813540F0AB405;
  localparam logic [63:0] PT_B = 64'h0123456789AB0000;

  initial begin
    logic [63:0] ct_b;
    logic        seen;
    rst_n          = 1'b1;
    encrypt        = 1'b0;
    keys_64_in     = '0;
    change_keys_en = 1'b0;
    data_input_en  = 1'b0;
    data_64_in     = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_keys_valid", 64'(subkeys_16_valid), 64'd0);
    chk("rst_out_valid", 64'(data_output_valid), 64'd0);
    chk("rst_out_data", data_64_out, 64'd0);
    rst_n = 1'b0;
    wait_keys("rst");
    chk("rst_no_output", 64'(data_output_valid), 64'd0);

    // All-zero key generated automatically after reset
    send_one("zero_key", 64'd0, 64'h8CA64DE9C1B123A7);

    // Encrypt key schedule
    load_key(KEY, 1'b1);
    chk("strobe_clears_valid", 64'(subkeys_16_valid), 64'd0);
    wait_keys("enc");
    chk("enc_k1", 64'(dut.subkey_q[0]), 64'h1B02EFFC7072);
    chk("enc_k16", 64'(dut.subkey_q[15]), 64'hCB3D8B0E17F5);
    send_one("enc_a", PT_A, CT_A);

    // Back-to-back blocks
    data_64_in    = PT_A;
    data_input_en = 1'b1;
    tick();
    data_64_in    = PT_B;
    tick();
    data_input_en = 1'b0;
    wait_out("b2b_first", 16, CT_A);
    tick();
    chk("b2b_second_valid", 64'(data_output_valid), 64'd1);
    ct_b = data_64_out;
    tick();
    chk("b2b_end", 64'(data_output_valid), 64'd0);

    // Decrypt with reversed schedule
    load_key(KEY, 1'b0);
    wait_keys("dec");
    chk("dec_slot1", 64'(dut.subkey_q[0]), 64'hCB3D8B0E17F5);
    chk("dec_slot16", 64'(dut.subkey_q[15]), 64'h1B02EFFC7072);
    send_one("dec_a", CT_A, PT_A);
    send_one("dec_b", ct_b, PT_B);

    // Key change flushes in-flight block; input during regeneration ignored
    data_64_in    = PT_A;
    data_input_en = 1'b1;
    tick();
    data_input_en = 1'b0;
    repeat (4) tick();
    load_key(KEY, 1'b1);
    data_input_en = 1'b1;
    repeat (10) tick();
    data_input_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | data_output_valid;
    end
    chk("flush_no_output", 64'(seen), 64'd0);
    chk("flush_out_held", data_64_out, PT_B);
    chk("flush_keys_valid", 64'(subkeys_16_valid), 64'd1);

    // Strobe held three cycles: latency counts from the last one
    keys_64_in     = KEY;
    encrypt        = 1'b1;
    change_keys_en = 1'b1;
    repeat (3) tick();
    change_keys_en = 1'b0;
    wait_keys("multi");
    send_one("multi_enc", PT_A, CT_A);

    // Mid-operation reset reverts to the zero key
    data_64_in    = PT_A;
    data_input_en = 1'b1;
    tick();
    data_input_en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("mid_rst_keys", 64'(subkeys_16_valid), 64'd0);
    chk("mid_rst_data", data_64_out, 64'd0);
    wait_keys("mid_rst");
    chk("mid_rst_no_output", 64'(data_output_valid), 64'd0);
    send_one("mid_rst_zero", 64'd0, 64'h8CA64DE9C1B123A7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
